// File: rtl/fp_pkg.sv
// Purpose: shared FP32 field widths, operand classes, integer saturation constants
//          and the unpacked-operand record used by the FP pipelines.
// Ports:   none (package only).
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;
  localparam int BIAS      = 127;
  localparam int EXP_UNB_W = 10;  // holds -127..+128 with headroom

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUBN,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

  // out_flags = {NV, NX}
  localparam int FLAG_NV = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic                        sign;
    logic signed [EXP_UNB_W-1:0] exp_unb;  // exp - BIAS
    logic [MANT_W:0]             mag;      // {hidden bit, fraction}
    fp_class_e                   cls;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_to_int_pipe_if.sv
// Purpose: operand/result handshake bundle of the FP32 -> int32 converter.
// Ports:   in_valid/in_ready/in_data/in_signed (operand side),
//          out_valid/out_ready/out_data/out_flags (result side).
//          slave = converter view, master = producer/consumer view.
interface fp_to_int_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_flags;

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp_unpack.sv
// Purpose: combinational FP32 decode into sign, unbiased exponent, magnitude and class.
// Latency: 0 cycles (pure combinational); no backpressure, no state.
// Ports:   fp_dat (FP32 operand in), up (unpacked record out).
module fp_unpack
  import fp_pkg::*;
(
  input  logic [EXP_W+MANT_W:0] fp_dat,
  output fp_unpacked_t          up
);

  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] frac_f;

  assign exp_f  = fp_dat[MANT_W +: EXP_W];
  assign frac_f = fp_dat[MANT_W-1:0];

  always_comb begin
    up         = '0;
    up.sign    = fp_dat[EXP_W+MANT_W];
    up.exp_unb = $signed({2'b00, exp_f}) - $signed(EXP_UNB_W'(BIAS));
    // Hidden bit only for normals; subnormals keep a bare fraction.
    up.mag     = {exp_f != '0, frac_f};
    if (exp_f == '1) begin
      up.cls = (frac_f != '0) ? FP_NAN : FP_INF;
    end else if (exp_f == '0) begin
      up.cls = (frac_f != '0) ? FP_SUBN : FP_ZERO;
    end else begin
      up.cls = FP_NORM;
    end
  end

endmodule

// File: rtl/fp_to_int_pipe.sv
// Purpose: FP32 -> int32/uint32 converter (vfcvt.x.f / vfcvt.xu.f) with RISC-V
//          saturation and {NV, NX} flags. Stages: S1 unpack, S2 shift, S3 round/saturate/sign.
// Latency: 3 register stages accept->out_valid, 1 result/cycle while out_ready=1.
// Backpressure: whole pipe advances only when !out_valid || out_ready; in_ready = that advance.
// Ports:   clk, reset (async active-high), io (fp_to_int_pipe_if.slave handshake bundle).
// Build:   FP2INT_RNE_EN defined -> round-to-nearest-even; undefined -> round toward zero.
module fp_to_int_pipe
  import fp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int MANT_W = fp_pkg::MANT_W
) (
  input  logic              clk,
  input  logic              reset,
  fp_to_int_pipe_if.slave   io
);

  if (WIDTH != 32 || EXP_W != 8 || MANT_W != 23) begin : g_bad_cfg
    $error("fp_to_int_pipe: only WIDTH=32, EXP_W=8, MANT_W=23 are supported");
  end

  typedef struct packed {
    logic        sign;
    logic        isgn;   // 1 = int32 target
    fp_class_e   cls;
    logic [32:0] mag;    // integer magnitude before rounding
    logic        rnd;    // first discarded bit
    logic        stk;    // OR of remaining discarded bits
    logic        ovf;    // exponent alone exceeds 32-bit range
  } s2_t;

  logic adv;

  // ---------------- S1: unpack ----------------
  fp_unpacked_t up;
  fp_unpacked_t s1_d, s1_q;
  logic         s1_vld_d, s1_vld_q;
  logic         s1_isgn_d, s1_isgn_q;

  // ---------------- S2: shift -----------------
  s2_t  s2_d, s2_q;
  logic s2_vld_d, s2_vld_q;

  // ---------------- S3: output ----------------
  logic             out_vld_d, out_vld_q;
  logic [WIDTH-1:0] out_dat_d, out_dat_q;
  logic [1:0]       out_flg_d, out_flg_q;

  assign adv         = !out_vld_q || io.out_ready;
  assign io.in_ready = adv;
  assign io.out_valid = out_vld_q;
  assign io.out_data  = out_dat_q;
  assign io.out_flags = out_flg_q;

  fp_unpack u_unpack (
    .fp_dat (io.in_data),
    .up     (up)
  );

  always_comb begin
    s1_vld_d  = adv ? io.in_valid : s1_vld_q;
    s1_d      = s1_q;
    s1_isgn_d = s1_isgn_q;
    if (adv && io.in_valid) begin
      s1_d      = up;
      s1_isgn_d = io.in_signed;
    end
  end

  // S2: align the 24-bit magnitude to an integer. For -1 <= e <= 23 the
  // magnitude is placed above 24 zero bits and shifted right, so the integer
  // part, round bit and sticky bits all fall out of one shifter without loss.
  logic signed [EXP_UNB_W-1:0] e_s1;
  logic signed [EXP_UNB_W-1:0] rsh_w;
  logic signed [EXP_UNB_W-1:0] lsh_w;
  logic [47:0]                 ext;

  always_comb begin
    e_s1     = s1_q.exp_unb;
    rsh_w    = 10'sd23 - e_s1;
    lsh_w    = e_s1 - 10'sd23;
    ext      = {s1_q.mag, 24'b0} >> rsh_w[4:0];
    s2_vld_d = adv ? s1_vld_q : s2_vld_q;
    s2_d     = s2_q;
    if (adv && s1_vld_q) begin
      s2_d.sign = s1_q.sign;
      s2_d.isgn = s1_isgn_q;
      s2_d.cls  = s1_q.cls;
      s2_d.mag  = '0;
      s2_d.rnd  = 1'b0;
      s2_d.stk  = 1'b0;
      s2_d.ovf  = 1'b0;
      if (e_s1 < -10'sd1) begin
        // |x| < 0.5 (covers zeros and subnormals): everything is sticky.
        s2_d.stk = |s1_q.mag;
      end else if (e_s1 <= 10'sd23) begin
        s2_d.mag = {9'b0, ext[47:24]};
        s2_d.rnd = ext[23];
        s2_d.stk = |ext[22:0];
      end else if (e_s1 <= 10'sd31) begin
        s2_d.mag = {9'b0, s1_q.mag} << lsh_w[3:0];
      end else begin
        s2_d.ovf = 1'b1;
      end
    end
  end

  // S3: round, range check, then negate.
  logic [32:0]      rmag;
  logic             inexact;
  logic [WIDTH-1:0] sat_pos;
  logic [WIDTH-1:0] sat_neg;
  logic [WIDTH-1:0] res_dat;
  logic [1:0]       res_flg;

  always_comb begin
`ifdef FP2INT_RNE_EN
    rmag = s2_q.mag + {32'b0, s2_q.rnd && (s2_q.stk || s2_q.mag[0])};
`else
    rmag = s2_q.mag;
`endif
    inexact = s2_q.rnd || s2_q.stk;
    sat_pos = s2_q.isgn ? INT32_MAX : UINT32_MAX;
    sat_neg = s2_q.isgn ? INT32_MIN : '0;
    res_dat = '0;
    res_flg = '0;

    if (s2_q.cls == FP_NAN) begin
      res_dat          = sat_pos;
      res_flg[FLAG_NV] = 1'b1;
    end else if (s2_q.cls == FP_INF || s2_q.ovf) begin
      res_dat          = s2_q.sign ? sat_neg : sat_pos;
      res_flg[FLAG_NV] = 1'b1;
    end else if (s2_q.isgn) begin
      // Negative side reaches one further: -2^31 is representable.
      if (rmag > (s2_q.sign ? 33'h0_8000_0000 : 33'h0_7FFF_FFFF)) begin
        res_dat          = s2_q.sign ? sat_neg : sat_pos;
        res_flg[FLAG_NV] = 1'b1;
      end else begin
        res_dat          = s2_q.sign ? (~rmag[31:0] + 32'd1) : rmag[31:0];
        res_flg[FLAG_NX] = inexact;
      end
    end else if (s2_q.sign) begin
      // Negative to unsigned: only values that round to zero are legal.
      if (rmag == '0) begin
        res_flg[FLAG_NX] = inexact;
      end else begin
        res_flg[FLAG_NV] = 1'b1;
      end
    end else if (rmag > 33'h0_FFFF_FFFF) begin
      res_dat          = sat_pos;
      res_flg[FLAG_NV] = 1'b1;
    end else begin
      res_dat          = rmag[31:0];
      res_flg[FLAG_NX] = inexact;
    end
  end

  always_comb begin
    out_vld_d = adv ? s2_vld_q : out_vld_q;
    out_dat_d = out_dat_q;
    out_flg_d = out_flg_q;
    if (adv && s2_vld_q) begin
      out_dat_d = res_dat;
      out_flg_d = res_flg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      s1_isgn_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_q      <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_flg_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_q      <= s1_d;
      s1_isgn_q <= s1_isgn_d;
      s2_vld_q  <= s2_vld_d;
      s2_q      <= s2_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_flg_q <= out_flg_d;
    end
  end

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Purpose: self-checking bench for fp_to_int_pipe: directed corner values,
//          back-pressure ordering/hold, mid-flight reset and random operands
//          against a real-arithmetic reference model.
// Latency/backpressure: checked through a result queue and per-cycle hold checks.
module tb_fp_to_int_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_to_int_pipe_if #(.WIDTH(32)) io ();

  fp_to_int_pipe u_dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [33:0] exp_q[$];
  logic        use_tbl   = 1'b0;
  logic [33:0] tbl_exp   = '0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out  = '0;
  logic        acc_flag  = 1'b0;
  int          n_rcv     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
    end
  endtask

  // Reference: value as a real number, rounded with plain arithmetic, then
  // range-checked against the integer target.
  function automatic logic [33:0] ref_cvt(input logic [31:0] f, input logic sgn);
    logic   s;
    int     ex;
    int     fr;
    real    a, r, mr, kr;
    logic   nx;
    longint v;
`ifdef FP2INT_RNE_EN
    real    d;
`endif
    s  = f[31];
    ex = int'(f[30:23]);
    fr = int'(f[22:0]);
    if (ex == 255) begin
      if (fr != 0) return {sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF, 2'b10};
      if (s)       return {sgn ? 32'h8000_0000 : 32'h0000_0000, 2'b10};
      return {sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF, 2'b10};
    end
    mr = (ex != 0) ? real'(fr + 8388608) : real'(fr);
    kr = (ex != 0) ? real'(ex - 150) : -149.0;
    a  = mr * (2.0 ** kr);
    r  = $floor(a);
`ifdef FP2INT_RNE_EN
    d = a - r;
    if (d > 0.5) r = r + 1.0;
    else if (d == 0.5 && (longint'(r) % 2 == 1)) r = r + 1.0;
`endif
    nx = (a != r);
    if (sgn) begin
      if (r > (s ? 2147483648.0 : 2147483647.0))
        return {s ? 32'h8000_0000 : 32'h7FFF_FFFF, 2'b10};
      v = longint'(r);
      if (s) v = -v;
      return {v[31:0], 1'b0, nx};
    end
    if (s) return (r == 0.0) ? {32'h0, 1'b0, nx} : {32'h0, 2'b10};
    if (r > 4294967295.0) return {32'hFFFF_FFFF, 2'b10};
    v = longint'(r);
    return {v[31:0], 1'b0, nx};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] fr;
    fr = 23'($urandom);
    if ($urandom_range(0, 4) == 0) fr = '0;
    case ($urandom_range(0, 9))
      0:       e = 8'd0;
      1:       e = 8'd255;
      2, 3, 4, 5, 6: e = 8'($urandom_range(118, 160));
      default: e = 8'($urandom);
    endcase
    return {1'($urandom), e, fr};
  endfunction

  // Observation point: half a cycle after the active edge.
  task automatic monitor();
    logic [33:0] e;
    chk("in_rdy", {63'b0, io.in_ready}, {63'b0, (!io.out_valid || io.out_ready)});
    if (prev_stall)
      chk("hold", {30'b0, io.out_data, io.out_flags}, {30'b0, prev_out});
    if (io.out_valid && io.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious", {63'b0, io.out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res", {30'b0, io.out_data, io.out_flags}, {30'b0, e});
        n_rcv++;
      end
    end
    acc_flag = io.in_valid && io.in_ready;
    if (acc_flag)
      exp_q.push_back(use_tbl ? tbl_exp : ref_cvt(io.in_data, io.in_signed));
    prev_stall = io.out_valid && !io.out_ready;
    prev_out   = {io.out_data, io.out_flags};
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] fp;
    logic        sgn;
    logic [33:0] exp_v;
  } dir_t;

  dir_t dir_tbl[12];

  initial begin
`ifdef FP2INT_RNE_EN
    dir_tbl[0]  = '{32'h3FC0_0000, 1'b1, {32'd2, 2'b01}};
`else
    dir_tbl[0]  = '{32'h3FC0_0000, 1'b1, {32'd1, 2'b01}};
`endif
    dir_tbl[1]  = '{32'h4020_0000, 1'b1, {32'd2, 2'b01}};
    dir_tbl[2]  = '{32'hCF00_0000, 1'b1, {32'h8000_0000, 2'b00}};
    dir_tbl[3]  = '{32'h4F00_0000, 1'b1, {32'h7FFF_FFFF, 2'b10}};
    dir_tbl[4]  = '{32'h4F00_0000, 1'b0, {32'h8000_0000, 2'b00}};
    dir_tbl[5]  = '{32'h7FC0_0000, 1'b1, {32'h7FFF_FFFF, 2'b10}};
    dir_tbl[6]  = '{32'h7FC0_0000, 1'b0, {32'hFFFF_FFFF, 2'b10}};
    dir_tbl[7]  = '{32'hFF80_0000, 1'b0, {32'h0000_0000, 2'b10}};
    dir_tbl[8]  = '{32'hBF00_0000, 1'b0, {32'h0000_0000, 2'b01}};
    dir_tbl[9]  = '{32'hBF80_0000, 1'b0, {32'h0000_0000, 2'b10}};
    dir_tbl[10] = '{32'h0000_0001, 1'b1, {32'h0000_0000, 2'b01}};
    dir_tbl[11] = '{32'h8000_0000, 1'b1, {32'h0000_0000, 2'b00}};

    reset        = 1'b1;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.in_signed = 1'b0;
    io.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_ovld",  {63'b0, io.out_valid}, 64'd0);
    chk("rst_odat",  {32'b0, io.out_data},  64'd0);
    chk("rst_oflg",  {62'b0, io.out_flags}, 64'd0);
    chk("rst_irdy",  {63'b0, io.in_ready},  64'd1);

    // Directed corner values, back to back.
    use_tbl = 1'b1;
    for (int i = 0; i < 12; i++) begin
      io.in_valid  = 1'b1;
      io.in_data   = dir_tbl[i].fp;
      io.in_signed = dir_tbl[i].sgn;
      tbl_exp      = dir_tbl[i].exp_v;
      tick();
    end
    use_tbl     = 1'b0;
    io.in_valid = 1'b0;
    repeat (6) tick();
    chk("dir_drain", 64'(exp_q.size()), 64'd0);

    // Back-pressure: 8 operands, out_ready pattern 1-0-0-1.
    begin
      int sent = 0;
      int cyc  = 0;
      logic [3:0] patt = 4'b1001;
      n_rcv = 0;
      while ((sent < 8 || exp_q.size() != 0) && cyc < 80) begin
        io.out_ready = patt[cyc % 4];
        if (sent < 8) begin
          if (!io.in_valid || acc_flag) begin
            io.in_data   = rand_fp();
            io.in_signed = 1'($urandom);
          end
          io.in_valid = 1'b1;
        end else begin
          io.in_valid = 1'b0;
        end
        tick();
        if (acc_flag) sent++;
        cyc++;
      end
      io.in_valid = 1'b0;
      chk("bp_count", 64'(n_rcv), 64'd8);
    end

    // Reset with three operands in flight.
    io.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      io.in_valid  = 1'b1;
      io.in_data   = rand_fp();
      io.in_signed = 1'($urandom);
      tick();
    end
    io.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_ovld", {63'b0, io.out_valid}, 64'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    acc_flag   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stale", {63'b0, io.out_valid}, 64'd0);
      monitor();
      @(posedge clk);
      #1;
    end

    // Random operands with random valid/ready.
    for (int i = 0; i < 4000; i++) begin
      io.out_ready = ($urandom_range(0, 3) != 0);
      if (!io.in_valid || acc_flag) begin
        io.in_valid  = ($urandom_range(0, 3) != 0);
        io.in_data   = rand_fp();
        io.in_signed = 1'($urandom);
      end
      tick();
    end

    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
